// File: rtl/bitwise_unit_n.sv
// Two-stage pipelined bitwise logic unit with zero/negative flags behind a valid/ready handshake.
// S1 holds the accepted operands; S2 holds the registered result and its flags.
module bitwise_unit_n #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zr,
  output logic             out_ng
);

  localparam logic [2:0] OpNot  = 3'd0;
  localparam logic [2:0] OpAnd  = 3'd1;
  localparam logic [2:0] OpOr   = 3'd2;
  localparam logic [2:0] OpXor  = 3'd3;
  localparam logic [2:0] OpNand = 3'd4;
  localparam logic [2:0] OpNor  = 3'd5;
  localparam logic [2:0] OpXnor = 3'd6;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_zr;
  logic             r_out_ng;

  logic             w_s2_free;
  logic             w_s1_move;
  logic             w_s1_free;
  logic             w_accept;
  logic [WIDTH-1:0] w_result;

  // Ready depends only on the two valid bits and out_ready, never on data.
  assign w_s2_free = !r_out_valid || out_ready;
  assign w_s1_move = r_s1_valid && w_s2_free;
  assign w_s1_free = !r_s1_valid || w_s1_move;
  assign w_accept  = in_valid && w_s1_free;

  always_comb begin
    w_result = r_s1_a;
    case (r_s1_op)
      OpNot:   w_result = ~r_s1_a;
      OpAnd:   w_result = r_s1_a & r_s1_b;
      OpOr:    w_result = r_s1_a | r_s1_b;
      OpXor:   w_result = r_s1_a ^ r_s1_b;
      OpNand:  w_result = ~(r_s1_a & r_s1_b);
      OpNor:   w_result = ~(r_s1_a | r_s1_b);
      OpXnor:  w_result = ~(r_s1_a ^ r_s1_b);
      default: w_result = r_s1_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_op     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zr    <= 1'b0;
      r_out_ng    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
        r_s1_op    <= in_op;
      end else if (w_s1_move) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_move) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_zr    <= (w_result == '0);
        r_out_ng    <= w_result[WIDTH-1];
      end else if (w_s2_free) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_s1_free;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zr    = r_out_zr;
  assign out_ng    = r_out_ng;

endmodule

// File: tb/tb_bitwise_unit_n.sv
// Self-checking bench for bitwise_unit_n: directed WIDTH=16 scenarios plus random
// scoreboarded traffic on WIDTH=4 and WIDTH=32 instances.
module tb_bitwise_unit_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        s16_in_valid, s16_in_ready, s16_out_valid, s16_out_ready, s16_out_zr, s16_out_ng;
  logic [15:0] s16_in_a, s16_in_b, s16_out_data;
  logic [2:0]  s16_in_op;
  logic        s4_in_valid, s4_in_ready, s4_out_valid, s4_out_ready, s4_out_zr, s4_out_ng;
  logic [3:0]  s4_in_a, s4_in_b, s4_out_data;
  logic [2:0]  s4_in_op;
  logic        s32_in_valid, s32_in_ready, s32_out_valid, s32_out_ready, s32_out_zr, s32_out_ng;
  logic [31:0] s32_in_a, s32_in_b, s32_out_data;
  logic [2:0]  s32_in_op;

  int total = 0;
  int bad = 0;

  bitwise_unit_n #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(s16_in_valid), .in_ready(s16_in_ready),
    .in_a(s16_in_a), .in_b(s16_in_b), .in_op(s16_in_op), .out_valid(s16_out_valid),
    .out_ready(s16_out_ready), .out_data(s16_out_data), .out_zr(s16_out_zr), .out_ng(s16_out_ng)
  );
  bitwise_unit_n #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(s4_in_valid), .in_ready(s4_in_ready),
    .in_a(s4_in_a), .in_b(s4_in_b), .in_op(s4_in_op), .out_valid(s4_out_valid),
    .out_ready(s4_out_ready), .out_data(s4_out_data), .out_zr(s4_out_zr), .out_ng(s4_out_ng)
  );
  bitwise_unit_n #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(s32_in_valid), .in_ready(s32_in_ready),
    .in_a(s32_in_a), .in_b(s32_in_b), .in_op(s32_in_op), .out_valid(s32_out_valid),
    .out_ready(s32_out_ready), .out_data(s32_out_data), .out_zr(s32_out_zr), .out_ng(s32_out_ng)
  );

  // Reference: op semantics on zero-extended operands, truncated to w bits.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    logic [31:0] r;
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (op)
      3'd0:    r = ~a;
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = a ^ b;
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = ~(a ^ b);
      default: r = a;
    endcase
    return r & m;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s16_in_valid = 0; s16_out_ready = 0; s16_in_a = '0; s16_in_b = '0; s16_in_op = '0;
    s4_in_valid = 0;  s4_out_ready = 0;  s4_in_a = '0;  s4_in_b = '0;  s4_in_op = '0;
    s32_in_valid = 0; s32_out_ready = 0; s32_in_a = '0; s32_in_b = '0; s32_in_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (s16_out_valid !== 1'b0) begin bad++;
        $display("FAIL reset_out_valid: got %b want 0", s16_out_valid); end
      total++; if (s16_out_data !== 16'h0000) begin bad++;
        $display("FAIL reset_out_data: got %h want 0000", s16_out_data); end
      total++; if (s16_out_zr !== 1'b0) begin bad++;
        $display("FAIL reset_out_zr: got %b want 0", s16_out_zr); end
      total++; if (s16_out_ng !== 1'b0) begin bad++;
        $display("FAIL reset_out_ng: got %b want 0", s16_out_ng); end
      total++; if (s16_in_ready !== 1'b1) begin bad++;
        $display("FAIL reset_in_ready: got %b want 1", s16_in_ready); end
      step();
    end
  endtask

  task automatic test_op_sweep();
    logic [15:0] exp_sw [8];
    exp_sw = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
    s16_out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        s16_in_valid = 1'b1; s16_in_a = 16'hF0F0; s16_in_b = 16'hFF00; s16_in_op = 3'(c);
      end else begin
        s16_in_valid = 1'b0;
      end
      #1;
      if (c >= 2 && c < 10) begin
        total++; if (s16_out_valid !== 1'b1 || s16_out_data !== exp_sw[c-2]) begin bad++;
          $display("FAIL sweep_op%0d: got v=%b d=%h want v=1 d=%h", c-2, s16_out_valid,
                   s16_out_data, exp_sw[c-2]); end
        total++; if (s16_out_ng !== exp_sw[c-2][15]) begin bad++;
          $display("FAIL sweep_ng_op%0d: got %b want %b", c-2, s16_out_ng, exp_sw[c-2][15]); end
      end else begin
        total++; if (s16_out_valid !== 1'b0) begin bad++;
          $display("FAIL sweep_idle_c%0d: got out_valid=%b want 0", c, s16_out_valid); end
      end
      step();
    end
  endtask

  task automatic test_flags();
    logic [15:0] fa [3];
    logic [15:0] fb [3];
    logic [15:0] fr [3];
    logic [2:0]  fo [3];
    logic        fz [3];
    logic        fn [3];
    fa = '{16'hFFFF, 16'h8000, 16'h1234};
    fb = '{16'h5555, 16'hAAAA, 16'h1234};
    fo = '{3'd0, 3'd7, 3'd3};
    fr = '{16'h0000, 16'h8000, 16'h0000};
    fz = '{1'b1, 1'b0, 1'b1};
    fn = '{1'b0, 1'b1, 1'b0};
    s16_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s16_in_valid = 1'b1; s16_in_a = fa[i]; s16_in_b = fb[i]; s16_in_op = fo[i];
      step();
      s16_in_valid = 1'b0;
      step();
      #1;
      total++; if (s16_out_valid !== 1'b1 || s16_out_data !== fr[i]) begin bad++;
        $display("FAIL flags_data%0d: got v=%b d=%h want v=1 d=%h", i, s16_out_valid,
                 s16_out_data, fr[i]); end
      total++; if (s16_out_zr !== fz[i] || s16_out_ng !== fn[i]) begin bad++;
        $display("FAIL flags_zr_ng%0d: got zr=%b ng=%b want zr=%b ng=%b", i, s16_out_zr,
                 s16_out_ng, fz[i], fn[i]); end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [15:0] w [3];
    logic [15:0] got [$];
    logic        acc;
    for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
    s16_out_ready = 1'b0;
    s16_in_op = 3'd7; s16_in_b = '0;
    for (int i = 0; i < 2; i++) begin
      s16_in_valid = 1'b1; s16_in_a = w[i];
      #1;
      total++; if (s16_in_ready !== 1'b1) begin bad++;
        $display("FAIL bp_accept%0d: got in_ready=%b want 1", i, s16_in_ready); end
      step();
    end
    s16_in_valid = 1'b1; s16_in_a = w[2];
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (s16_in_ready !== 1'b0) begin bad++;
        $display("FAIL bp_in_ready_stall%0d: got %b want 0", k, s16_in_ready); end
      total++; if (s16_out_valid !== 1'b1 || s16_out_data !== w[0]) begin bad++;
        $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=%h", k, s16_out_valid,
                 s16_out_data, w[0]); end
      step();
    end
    s16_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      acc = s16_in_valid && s16_in_ready;
      if (s16_out_valid) got.push_back(s16_out_data);
      step();
      if (acc) s16_in_valid = 1'b0;
    end
    total++; if (got.size() != 3) begin bad++;
      $display("FAIL bp_count: got %0d words want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (i >= got.size() || got[i] !== w[i]) begin bad++;
        $display("FAIL bp_order%0d: got %h want %h", i, (i < got.size()) ? got[i] : 16'hxxxx,
                 w[i]); end
    end
  endtask

  task automatic test_midflight_reset();
    logic [15:0] wy;
    wy = 16'($urandom) | 16'h0001;
    s16_out_ready = 1'b0; s16_in_op = 3'd7;
    for (int i = 0; i < 2; i++) begin
      s16_in_valid = 1'b1; s16_in_a = 16'($urandom);
      step();
    end
    #1;
    total++; if (s16_out_valid !== 1'b1 || s16_in_ready !== 1'b0) begin bad++;
      $display("FAIL mr_full: got v=%b rdy=%b want v=1 rdy=0", s16_out_valid, s16_in_ready); end
    reset = 1'b1;
    step();
    reset = 1'b0; s16_in_valid = 1'b0; s16_out_ready = 1'b1;
    #1;
    total++; if (s16_out_valid !== 1'b0 || s16_in_ready !== 1'b1) begin bad++;
      $display("FAIL mr_after: got v=%b rdy=%b want v=0 rdy=1", s16_out_valid, s16_in_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      total++; if (s16_out_valid !== 1'b0) begin bad++;
        $display("FAIL mr_stale%0d: got out_valid=%b want 0", k, s16_out_valid); end
    end
    s16_in_valid = 1'b1; s16_in_a = wy;
    step();
    s16_in_valid = 1'b0;
    #1;
    total++; if (s16_out_valid !== 1'b0) begin bad++;
      $display("FAIL mr_early: got out_valid=%b want 0", s16_out_valid); end
    step();
    #1;
    total++; if (s16_out_valid !== 1'b1 || s16_out_data !== wy) begin bad++;
      $display("FAIL mr_word: got v=%b d=%h want v=1 d=%h", s16_out_valid, s16_out_data, wy); end
    step();
    #1;
    total++; if (s16_out_valid !== 1'b0) begin bad++;
      $display("FAIL mr_alone: got out_valid=%b want 0", s16_out_valid); end
  endtask

  task automatic test_width();
    logic [3:0]  q4 [$];
    logic [31:0] q32 [$];
    logic        st4, st32;
    logic [3:0]  pd4, e4;
    logic [31:0] pd32, e32;
    st4 = 1'b0; st32 = 1'b0; pd4 = '0; pd32 = '0;
    for (int n = 0; n < 440; n++) begin
      if (n < 400) begin
        s4_in_valid = 1'($urandom); s4_in_a = 4'($urandom); s4_in_b = 4'($urandom);
        s4_in_op = 3'($urandom); s4_out_ready = ($urandom_range(0, 2) != 0);
        s32_in_valid = 1'($urandom); s32_in_a = $urandom; s32_in_b = $urandom;
        s32_in_op = 3'($urandom); s32_out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        s4_in_valid = 1'b0; s4_out_ready = 1'b1;
        s32_in_valid = 1'b0; s32_out_ready = 1'b1;
      end
      #1;
      if (st4) begin
        total++; if (s4_out_valid !== 1'b1 || s4_out_data !== pd4) begin bad++;
          $display("FAIL w4_stall: got v=%b d=%h want v=1 d=%h", s4_out_valid, s4_out_data, pd4); end
      end
      if (s4_out_valid && s4_out_ready) begin
        total++;
        if (q4.size() == 0) begin bad++;
          $display("FAIL w4_extra: got d=%h want no word", s4_out_data);
        end else begin
          e4 = q4.pop_front();
          if (s4_out_data !== e4 || s4_out_zr !== (e4 == 4'h0) || s4_out_ng !== e4[3]) begin
            bad++;
            $display("FAIL w4_result: got d=%h zr=%b ng=%b want d=%h zr=%b ng=%b", s4_out_data,
                     s4_out_zr, s4_out_ng, e4, (e4 == 4'h0), e4[3]);
          end
        end
      end
      if (s4_in_valid && s4_in_ready)
        q4.push_back(4'(model(s4_in_op, {28'h0, s4_in_a}, {28'h0, s4_in_b}, 4)));
      st4 = s4_out_valid && !s4_out_ready; pd4 = s4_out_data;

      if (st32) begin
        total++; if (s32_out_valid !== 1'b1 || s32_out_data !== pd32) begin bad++;
          $display("FAIL w32_stall: got v=%b d=%h want v=1 d=%h", s32_out_valid, s32_out_data,
                   pd32); end
      end
      if (s32_out_valid && s32_out_ready) begin
        total++;
        if (q32.size() == 0) begin bad++;
          $display("FAIL w32_extra: got d=%h want no word", s32_out_data);
        end else begin
          e32 = q32.pop_front();
          if (s32_out_data !== e32 || s32_out_zr !== (e32 == 32'h0) || s32_out_ng !== e32[31]) begin
            bad++;
            $display("FAIL w32_result: got d=%h zr=%b ng=%b want d=%h zr=%b ng=%b", s32_out_data,
                     s32_out_zr, s32_out_ng, e32, (e32 == 32'h0), e32[31]);
          end
        end
      end
      if (s32_in_valid && s32_in_ready)
        q32.push_back(model(s32_in_op, s32_in_a, s32_in_b, 32));
      st32 = s32_out_valid && !s32_out_ready; pd32 = s32_out_data;
      step();
    end
    total++; if (q4.size() != 0) begin bad++;
      $display("FAIL w4_lost: got %0d words left want 0", q4.size()); end
    total++; if (q32.size() != 0) begin bad++;
      $display("FAIL w32_lost: got %0d words left want 0", q32.size()); end
  endtask

  initial begin
    test_reset();
    test_op_sweep();
    test_flags();
    test_backpressure();
    test_midflight_reset();
    test_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
